// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial LSB-first adder with one full-adder stage
//
// Adds two WIDTH-bit operands plus carry-in, one bit per clock, through a
// single 1-bit full adder and a carry flop. A start accepted in IDLE loads
// the operands; WIDTH RUN cycles later the result is loaded into sum/cout
// and done pulses for one cycle.
//
// Optional feature macro: SERIAL_ADDER_OVF_EN adds the signed overflow
// output ovf (carry into MSB XOR carry out), loaded and held with sum.
//
// Ports:
//   clk    in   1      clock, rising edge
//   rst    in   1      synchronous active-high reset
//   start  in   1      begin an addition (sampled only in IDLE)
//   a, b   in   WIDTH  operands, captured on the accepted start edge
//   cin    in   1      carry-in, captured with a and b
//   busy   out  1      high while the addition is running
//   done   out  1      one-cycle pulse: sum/cout (and ovf) are valid
//   sum    out  WIDTH  registered result, held until the next completion
//   cout   out  1      registered carry out of bit WIDTH-1
//   ovf    out  1      signed overflow (only with SERIAL_ADDER_OVF_EN)

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] areg;
    logic [WIDTH-1:0] breg;
    // Holds the WIDTH-1 sum bits produced so far; the last bit is joined on
    // the final RUN edge straight into the sum output, so no bit of the
    // internal register is ever shifted out unused.
    logic [WIDTH-2:0] sreg;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             s_bit;
    logic             c_next;
    logic [WIDTH-1:0] sfull;

    always_comb begin
        s_bit  = areg[0] ^ breg[0] ^ carry;
        c_next = (areg[0] & breg[0]) | ((areg[0] ^ breg[0]) & carry);
        sfull  = {s_bit, sreg};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            areg  <= '0;
            breg  <= '0;
            sreg  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        areg  <= a;
                        breg  <= b;
                        carry <= cin;
                        sreg  <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    areg  <= areg >> 1;
                    breg  <= breg >> 1;
                    sreg  <= sfull[WIDTH-1:1];
                    carry <= c_next;
                    cnt   <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        sum   <= sfull;
                        cout  <= c_next;
`ifdef SERIAL_ADDER_OVF_EN
                        // carry still holds the carry into the MSB here
                        ovf   <= carry ^ c_next;
`endif
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - self-checking bench for serial_adder (WIDTH=8)

module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] s;
        logic         co;
        logic         ov;
    } vec_t;

    vec_t vecs[8];

    // Launch one addition; returns edges from acceptance until done is seen
    // and the number of busy cycles observed before done.
    task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic,
                          output int lat, output int bcnt);
        @(negedge clk);
        a = ia; b = ib; cin = ic; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        bcnt = 0;
        while (!done && lat < 40) begin
            if (busy) bcnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat, bcnt, dones, changes, p1, p2;
        logic [W-1:0] prev, got;

        vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[5] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[6] = '{8'h55, 8'h2A, 1'b0, 8'h7F, 1'b0, 1'b0};
        vecs[7] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0};

        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset sum", sum, 0);
        chk("reset cout", cout, 0);
`ifdef SERIAL_ADDER_OVF_EN
        chk("reset ovf", ovf, 0);
`endif
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, lat, bcnt);
            chk($sformatf("vec%0d done edge", i), lat + 1, W + 1);
            chk($sformatf("vec%0d busy cycles", i), bcnt, W);
            chk($sformatf("vec%0d busy at done", i), busy, 0);
            chk($sformatf("vec%0d sum", i), sum, vecs[i].s);
            chk($sformatf("vec%0d cout", i), cout, vecs[i].co);
`ifdef SERIAL_ADDER_OVF_EN
            chk($sformatf("vec%0d ovf", i), ovf, vecs[i].ov);
`endif
            @(negedge clk);
            chk($sformatf("vec%0d done one cycle", i), done, 0);
            chk($sformatf("vec%0d sum held", i), sum, vecs[i].s);
        end

        // Start re-pulsed and operands changed during RUN must be ignored.
        prev = sum;
        @(negedge clk);
        a = 8'h11; b = 8'h22; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dones = 0; changes = 0; got = '0;
        for (int i = 0; i < 20; i++) begin
            if (i == 2) begin start = 1'b1; a = 8'hAA; b = 8'hAA; end
            if (i == 3) start = 1'b0;
            if (i == 5) begin a = 8'hFF; b = 8'hFF; end
            if (busy && sum != prev) changes++;
            if (done) begin dones++; got = sum; end
            @(negedge clk);
        end
        chk("ignore start dones", dones, 1);
        chk("ignore start sum", got, 8'h33);
        chk("ignore start cout", cout, 0);
        chk("sum stable mid-run", changes, 0);

        // Reset in cycle 4 of RUN aborts the operation; start with rst is dropped.
        @(negedge clk);
        a = 8'hF0; b = 8'h0F; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        chk("abort busy", busy, 0);
        chk("abort done", done, 0);
        chk("abort sum", sum, 0);
        chk("abort cout", cout, 0);
`ifdef SERIAL_ADDER_OVF_EN
        chk("abort ovf", ovf, 0);
`endif
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("start with rst discarded", busy, 0);
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) dones++;
            @(negedge clk);
        end
        chk("abort no done", dones, 0);
        run_op(8'h05, 8'h03, 1'b0, lat, bcnt);
        chk("post-abort done edge", lat + 1, W + 1);
        chk("post-abort sum", sum, 8'h08);
        chk("post-abort cout", cout, 0);
        @(negedge clk);

        // Continuous start: back-to-back operations.
        @(negedge clk);
        a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
        p1 = -1; p2 = -1; changes = 0;
        for (int t = 0; t < 40 && p2 < 0; t++) begin
            @(negedge clk);
            if (done) begin
                if (p1 < 0) begin
                    p1 = t;
                    chk("b2b first sum", sum, 8'h02);
                end else begin
                    p2 = t;
                    chk("b2b second sum", sum, 8'h02);
                end
            end else if (p1 >= 0 && sum != 8'h02) begin
                changes++;
            end
        end
        start = 1'b0;
        chk("b2b first seen", (p1 >= 0) ? 1 : 0, 1);
        chk("b2b pulse spacing", p2 - p1, 10);
        chk("b2b sum stable", changes, 0);
        repeat (12) @(negedge clk);
        chk("b2b idle after", busy, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1, request to begin an addition; sampled only in IDLE.
REQ-005 The block SHALL have ports a and b, input, WIDTH each, the operands, captured on the accepted start edge.
REQ-006 The block SHALL have port cin, input, 1, the carry-in, captured with a and b.
REQ-007 The block SHALL have port busy, output, 1, high while in RUN.
REQ-008 The block SHALL have port done, output, 1, a one-cycle pulse marking sum and cout valid.
REQ-009 The block SHALL have ports sum (output, WIDTH) and cout (output, 1), the registered result.

Function
REQ-010 The block SHALL add serially LSB-first, one bit per cycle, through a single 1-bit full-adder stage (s = x^y^c, c' = x&y | (x^y)&c) with a carry flip-flop.
REQ-011 The FSM SHALL have states IDLE, RUN and DONE, and SHALL enter IDLE on reset.
REQ-012 In IDLE with start=1 at an edge, the block SHALL load a, b and cin into internal shift registers and the carry flop, clear the bit counter, and move to RUN.
REQ-013 In IDLE with start=0, the block SHALL remain in IDLE with all outputs held.
REQ-014 Each RUN cycle SHALL consume bit 0 of the operand registers, shift them right by one, shift the sum bit into the MSB of the internal sum register, update carry, and increment the counter.
REQ-015 RUN SHALL last exactly WIDTH cycles; on the edge where counter==WIDTH-1, the FSM SHALL move to DONE.
REQ-016 On that same edge, sum and cout SHALL be loaded from the internal sum register and final carry.
REQ-017 In DONE, done SHALL be 1 for exactly one cycle, and the FSM SHALL return to IDLE on the next edge.
REQ-018 With start accepted at edge k, done SHALL be high in the cycle following edge k+WIDTH, for a latency of WIDTH+1 edges.
REQ-019 start SHALL be ignored in RUN and DONE, with no effect on operands or result.
REQ-020 sum and cout SHALL hold their last result until the next DONE load, so they never change mid-operation.
REQ-021 Operand changes after the accepted start SHALL NOT affect the result.
REQ-022 Arithmetic SHALL be modulo 2^WIDTH, with the carry out of bit WIDTH-1 presented on cout.
REQ-023 start asserted continuously SHALL yield back-to-back operations, each new start accepted in the IDLE cycle after DONE.

Reset
REQ-024 rst=1 SHALL force state IDLE, busy=0, done=0, sum=0, cout=0, counter=0, carry=0 and shift registers=0 on the next edge.
REQ-025 rst SHALL take priority over start and over any in-flight operation; an aborted operation SHALL produce no done pulse and no sum/cout update.
REQ-026 start sampled in the same cycle as rst=1 SHALL be discarded.

Configuration
REQ-027 When macro SERIAL_ADDER_OVF_EN is defined, the block SHALL add output port ovf (1 bit): signed two's-complement overflow, equal to carry-into-MSB XOR cout.
REQ-028 ovf SHALL be loaded and held with sum and cout, and SHALL reset to 0.
REQ-029 Without SERIAL_ADDER_OVF_EN, port ovf and its logic SHALL be absent, with all other behaviour identical.

Verification (WIDTH=8)
REQ-030 The bench SHALL apply a=0x0F, b=0x01, cin=0 and require done at edge k+9, sum=0x10, cout=0, and busy high for exactly 8 cycles.
REQ-031 The bench SHALL apply a=0xFF, b=0x01, cin=0, then a=0xFF, b=0x00, cin=1, and require sum=0x00, cout=1 for both (and ovf=0 when enabled).
REQ-032 The bench SHALL apply a=0x7F, b=0x01, cin=0 and require sum=0x80, cout=0, with ovf=1 when SERIAL_ADDER_OVF_EN is defined.
REQ-033 The bench SHALL pulse start with a=0x11, b=0x22, re-pulse start with a=0xAA, b=0xAA in cycle 3 of RUN, and change a/b mid-RUN, and require sum=0x33 and only one done.
REQ-034 The bench SHALL assert rst in cycle 4 of RUN and require no done, all outputs 0 and IDLE; a fresh start with a=0x05, b=0x03 SHALL then give sum=0x08.
REQ-035 The bench SHALL hold start=1 with a=0x01, b=0x01 and require done pulses 10 edges apart, sum=0x02, and sum stable between pulses.
